kronecker_zero_map: RTL and testbench

//  Pre/post stage around the d1 Kronecker-delta unit of the multiplicatively masked S-box.
//  - Registers and refreshes the 2-share Boolean input byte x, then drives it to the Kronecker unit.
//  - Delays x in lock-step with that unit's fixed latency, then maps zero to one:
//    x' = x XOR delta(x), so x' is never zero before the Boolean-to-multiplicative conversion.
//  - Forwards the shared delta downstream so the inversion result can be corrected back to zero.

---
 rtl/kronecker_zero_map.sv | 118 +++++++++++
 tb/tb_kronecker_zero_map.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kronecker_zero_map.sv
// Pre/post stage around the d1 Kronecker-delta unit: refreshes the shared input byte, delays it
// alongside the Kronecker unit, and maps x=0 to 1 share-wise while forwarding the shared delta.
module kronecker_zero_map #(
  parameter int KR_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_x0,
  input  logic [7:0]  in_x1,
  input  logic [7:0]  in_rand,
  output logic [15:0] kr_inp,
  input  logic [1:0]  kr_z,
  output logic        out_valid,
  output logic [7:0]  out_x0,
  output logic [7:0]  out_x1,
  output logic [1:0]  out_d,
  output logic        busy
);

  localparam int CW = $clog2(KR_LAT + 2);

  logic [15:0]             kr_inp_q, kr_inp_d;
  logic [KR_LAT:1][7:0]    dl0_q, dl0_d;
  logic [KR_LAT:1][7:0]    dl1_q, dl1_d;
  logic [KR_LAT:0]         v_q, v_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              out_x0_q, out_x0_d;
  logic [7:0]              out_x1_q, out_x1_d;
  logic [1:0]              out_d_q, out_d_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  // Input refresh, share-separated delay line, zero-to-one mapping and in-flight count.
  always_comb begin
    kr_inp_d    = kr_inp_q;
    dl0_d       = dl0_q;
    dl1_d       = dl1_q;
    v_d         = v_q;
    out_valid_d = v_q[KR_LAT];
    out_x0_d    = out_x0_q;
    out_x1_d    = out_x1_q;
    out_d_d     = out_d_q;
    cnt_d       = cnt_q;

    v_d[0] = in_valid;
    if (in_valid) begin
      kr_inp_d = {in_x1 ^ in_rand, in_x0 ^ in_rand};
    end else begin
      kr_inp_d = kr_inp_q;
    end

    dl0_d[1] = kr_inp_q[7:0];
    dl1_d[1] = kr_inp_q[15:8];
    for (int k = 2; k <= KR_LAT; k++) begin
      dl0_d[k] = dl0_q[k-1];
      dl1_d[k] = dl1_q[k-1];
    end
    for (int k = 1; k <= KR_LAT; k++) begin
      v_d[k] = v_q[k-1];
    end

    // Each delta share touches only bit 0 of its own data share, so no recombination occurs.
    if (v_q[KR_LAT]) begin
      out_x0_d = dl0_q[KR_LAT] ^ {7'b0000000, kr_z[0]};
      out_x1_d = dl1_q[KR_LAT] ^ {7'b0000000, kr_z[1]};
      out_d_d  = kr_z;
    end else begin
      out_x0_d = out_x0_q;
      out_x1_d = out_x1_q;
      out_d_d  = out_d_q;
    end

    case ({in_valid, out_valid_q})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards any byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kr_inp_q    <= 16'h0000;
      dl0_q       <= '0;
      dl1_q       <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      out_x0_q    <= 8'h00;
      out_x1_q    <= 8'h00;
      out_d_q     <= 2'b00;
      cnt_q       <= '0;
    end else begin
      kr_inp_q    <= kr_inp_d;
      dl0_q       <= dl0_d;
      dl1_q       <= dl1_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      out_x0_q    <= out_x0_d;
      out_x1_q    <= out_x1_d;
      out_d_q     <= out_d_d;
      cnt_q       <= cnt_d;
    end
  end

  assign kr_inp    = kr_inp_q;
  assign out_valid = out_valid_q;
  assign out_x0    = out_x0_q;
  assign out_x1    = out_x1_q;
  assign out_d     = out_d_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_kronecker_zero_map.sv
// Self-checking bench for kronecker_zero_map with a behavioural 3-cycle Kronecker unit model.
module tb_kronecker_zero_map;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x0 = 8'h00, in_x1 = 8'h00, in_rand = 8'h00;
  logic [15:0] kr_inp;
  logic [1:0]  kr_z;
  logic        out_valid, busy;
  logic [7:0]  out_x0, out_x1;
  logic [1:0]  out_d;

  int checks = 0;
  int errors = 0;

  kronecker_zero_map #(.KR_LAT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_x0(in_x0), .in_x1(in_x1),
    .in_rand(in_rand), .kr_inp(kr_inp), .kr_z(kr_z), .out_valid(out_valid),
    .out_x0(out_x0), .out_x1(out_x1), .out_d(out_d), .busy(busy)
  );

  always #5 clk = ~clk;

  // Kronecker unit model: three register levels, delta freshly masked with a random bit.
  logic       rnd = 1'b0;
  logic [1:0] kz_p1 = 2'b00, kz_p2 = 2'b00, kz_p3 = 2'b00, kz_seen = 2'b00;
  always @(negedge clk) rnd <= 1'($urandom);
  always @(posedge clk) begin
    kz_p1   <= {((kr_inp[7:0] ^ kr_inp[15:8]) == 8'h00) ^ rnd, rnd};
    kz_p2   <= kz_p1;
    kz_p3   <= kz_p2;
    kz_seen <= kz_p3;
  end
  assign kr_z = kz_p3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] r;
    logic [7:0] exp_x;
    logic       exp_dl;
  } vec_t;

  vec_t vecs [7];
  logic [7:0] gx0 [6];
  logic [7:0] gx1 [6];
  logic [7:0] hold_x0, hold_x1, sx;
  logic [5:0] pat;
  logic [8:0] sbq [$];
  logic [8:0] exp9;
  int bad;

  initial begin
    vecs[0] = '{8'h5A, 8'h5A, 8'h3C, 8'h01, 1'b1};
    vecs[1] = '{8'h12, 8'hB5, 8'hFF, 8'hA7, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'h77, 8'h01, 1'b0};
    vecs[3] = '{8'hC3, 8'h3C, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 8'h00, 8'h55, 8'h80, 1'b0};
    vecs[6] = '{8'hFE, 8'hFF, 8'hA0, 8'h01, 1'b0};

    // Reset state
    #3;
    chk("rst_kr_inp", 32'(kr_inp), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_x", 32'({out_x1, out_x0}), 32'h0);
    chk("rst_out_d", 32'(out_d), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single-byte vectors
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_x0 = vecs[i].x0;
      in_x1 = vecs[i].x1;
      in_rand = vecs[i].r;
      tick();
      chk("vec_kr_inp", 32'(kr_inp),
          32'({vecs[i].x1 ^ vecs[i].r, vecs[i].x0 ^ vecs[i].r}));
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("vec_early_valid", 32'(out_valid), 32'h0);
      chk("vec_busy_inflight", 32'(busy), 32'h1);
      tick();
      chk("vec_out_valid", 32'(out_valid), 32'h1);
      chk("vec_recomb", 32'(out_x0 ^ out_x1), 32'(vecs[i].exp_x));
      chk("vec_delta", 32'(out_d[0] ^ out_d[1]), 32'(vecs[i].exp_dl));
      chk("vec_out_d", 32'(out_d), 32'(kz_seen));
      chk("vec_share0", 32'(out_x0), 32'(vecs[i].x0 ^ vecs[i].r ^ {7'b0000000, kz_seen[0]}));
      chk("vec_share1", 32'(out_x1), 32'(vecs[i].x1 ^ vecs[i].r ^ {7'b0000000, kz_seen[1]}));
      tick();
      chk("vec_valid_drop", 32'(out_valid), 32'h0);
      chk("vec_busy_drop", 32'(busy), 32'h0);
    end

    // Back-to-back stream 00,01,FF,00
    for (int i = 0; i <= 8; i++) begin
      if (i < 4) begin
        case (i)
          0: sx = 8'h00;
          1: sx = 8'h01;
          2: sx = 8'hFF;
          default: sx = 8'h00;
        endcase
        in_valid = 1'b1;
        in_x0 = sx ^ 8'hA5;
        in_x1 = 8'hA5;
        in_rand = 8'(8'h3C + i);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i < 8) chk("str_busy", 32'(busy), 32'h1);
      if (i >= 4 && i < 8) begin
        chk("str_valid", 32'(out_valid), 32'h1);
        case (i)
          4: begin chk("str_x", 32'(out_x0 ^ out_x1), 32'h01); chk("str_d", 32'(^out_d), 32'h1); end
          5: begin chk("str_x", 32'(out_x0 ^ out_x1), 32'h01); chk("str_d", 32'(^out_d), 32'h0); end
          6: begin chk("str_x", 32'(out_x0 ^ out_x1), 32'hFF); chk("str_d", 32'(^out_d), 32'h0); end
          default: begin chk("str_x", 32'(out_x0 ^ out_x1), 32'h01); chk("str_d", 32'(^out_d), 32'h1); end
        endcase
      end
      if (i == 8) begin
        chk("str_end_valid", 32'(out_valid), 32'h0);
        chk("str_end_busy", 32'(busy), 32'h0);
      end
    end

    // Gapped pattern 1,0,0,1,0,1 (bit j = cycle j)
    pat = 6'b101001;
    for (int j = 0; j < 6; j++) begin
      gx0[j] = 8'(8'h10 + 8'(j * 17));
      gx1[j] = 8'(8'hC1 ^ 8'(j));
    end
    hold_x0 = 8'h00;
    hold_x1 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        in_valid = pat[i];
        in_x0 = gx0[i];
        in_x1 = gx1[i];
        in_rand = 8'h6B;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 4) begin
        chk("gap_valid", 32'(out_valid), 32'(pat[i-4]));
        if (pat[i-4]) begin
          hold_x0 = gx0[i-4] ^ 8'h6B ^ {7'b0000000, kz_seen[0]};
          hold_x1 = gx1[i-4] ^ 8'h6B ^ {7'b0000000, kz_seen[1]};
          chk("gap_recomb", 32'(out_x0 ^ out_x1), 32'(gx0[i-4] ^ gx1[i-4]));
        end
        chk("gap_x0", 32'(out_x0), 32'(hold_x0));
        chk("gap_x1", 32'(out_x1), 32'(hold_x1));
      end
    end

    // Reset with two bytes in flight
    in_valid = 1'b1; in_x0 = 8'h33; in_x1 = 8'h44; in_rand = 8'h99;
    tick();
    in_x0 = 8'h00; in_x1 = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("rmf_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rmf_kr_inp", 32'(kr_inp), 32'h0);
    chk("rmf_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rmf_no_output", 32'(bad), 32'h0);

    // Random stream against the scoreboard
    for (int i = 0; i < 10006; i++) begin
      if (i < 10000) begin
        in_valid = ($urandom_range(3, 0) != 0);
        in_x0 = 8'($urandom);
        in_x1 = (i % 7 == 0) ? in_x0 : 8'($urandom);
        in_rand = 8'($urandom);
        if (in_valid) begin
          sx = in_x0 ^ in_x1;
          sbq.push_back({(sx == 8'h00), (sx == 8'h00) ? 8'h01 : sx});
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("rnd_unexpected", 32'(out_valid), 32'h0);
        end else begin
          exp9 = sbq.pop_front();
          chk("rnd_out", 32'({^out_d, out_x0 ^ out_x1}), 32'(exp9));
        end
      end
    end
    chk("rnd_drained", 32'(sbq.size()), 32'h0);
    chk("rnd_busy_end", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
